register_file: RTL

REGISTER_FILE -- requirements
Module: register_file

---
 rtl/register_file_pkg.sv | 12 +
 rtl/register_file.sv | 77 +++++++
 2 files changed

// File: rtl/register_file_pkg.sv
// Shared definitions for register_file: clear-sequencer state encoding and default geometry.
package register_file_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_DEPTH = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

endpackage

// File: rtl/register_file.sv
// Two-read/one-write register file with a sequential clear engine.
// Define REGISTER_FILE_BYPASS_EN to forward write data to a matching read port in the write cycle.
module register_file
    import register_file_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] in,
    input  logic [AW-1:0]    raddr_a,
    input  logic [AW-1:0]    raddr_b,
    output logic [WIDTH-1:0] out_a,
    output logic [WIDTH-1:0] out_b,
    input  logic             clear,
    output logic             busy
);

    logic [WIDTH-1:0] mem [DEPTH];
    state_t           state;
    logic [AW-1:0]    cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // A write coinciding with a clear request still lands; the sweep zeroes it later.
                    if (load) begin
                        mem[waddr] <= in;
                    end
                    if (clear) begin
                        cnt   <= '0;
                        state <= CLEAR;
                        busy  <= 1'b1;
                    end
                end
                CLEAR: begin
                    mem[cnt] <= '0;
                    cnt      <= cnt + 1'b1;
                    if (cnt == AW'(DEPTH - 1)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        out_a = mem[raddr_a];
        out_b = mem[raddr_b];
`ifdef REGISTER_FILE_BYPASS_EN
        if (load && !busy && (waddr == raddr_a)) begin
            out_a = in;
        end
        if (load && !busy && (waddr == raddr_b)) begin
            out_b = in;
        end
`endif
    end

endmodule
